// File: rtl/fp12_result_queue.sv
`default_nettype none
// ============================================================================
// Module   : fp12_result_queue
// Purpose  : Elastic first-word-fall-through output queue for the 12-bit
//            floating-point multiplier (1 sign, 4 exponent, 7 mantissa bits).
//            Each entry holds a product word and its overflow flag. The block
//            also keeps a sticky overflow flag and a saturating count of
//            overflowing entries that were accepted.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            in_valid/in_ready     - producer handshake; in_z, in_of payload
//            out_valid/out_ready   - consumer handshake; out_z, out_of head
//            level                 - number of stored entries
//            clr_ovf               - synchronous clear of the statistics
//            ovf_sticky, ovf_cnt   - overflow statistics
// Revision : 1.0 - initial release
// ============================================================================
module fp12_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [11:0]                in_z,
    input  logic                       in_of,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [11:0]                out_z,
    output logic                       out_of,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       clr_ovf,
    output logic                       ovf_sticky,
    output logic [CNT_W-1:0]           ovf_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [12:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_ovf_sticky;
    logic [CNT_W-1:0]   r_ovf_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_ovf_event;
    logic [12:0]        w_head;

    // Handshake flags decode state only, so out_ready never reaches in_ready
    // combinationally; a full queue refuses a push even while it is popped.
    assign in_ready    = (r_level != c_LVL_W'(DEPTH));
    assign out_valid   = (r_level != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign w_ovf_event = w_push && in_of;

    assign w_head      = out_valid ? r_mem[r_rd_ptr] : 13'd0;
    assign out_of      = w_head[12];
    assign out_z       = w_head[11:0];
    assign level       = r_level;
    assign ovf_sticky  = r_ovf_sticky;
    assign ovf_cnt     = r_ovf_cnt;

    // Storage array carries no reset; stale contents are masked by r_level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_of, in_z};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_W'(1);
            end
        end
    end

    // A clear coinciding with an overflowing push keeps that event, so the
    // statistics restart at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt    <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (clr_ovf) begin
            r_ovf_cnt    <= w_ovf_event ? CNT_W'(1) : '0;
            r_ovf_sticky <= w_ovf_event;
        end else if (w_ovf_event) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp12_result_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp12_result_queue
// Purpose  : Self-checking bench for fp12_result_queue against a queue-based
//            reference model. A second instance with a 2-bit counter shares
//            all inputs to exercise counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp12_result_queue;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_z;
    logic        in_of;
    logic        out_ready;
    logic        clr_ovf;

    logic          in_ready,  in_ready2;
    logic          out_valid, out_valid2;
    logic [11:0]   out_z,     out_z2;
    logic          out_of,    out_of2;
    logic [LW-1:0] level,     level2;
    logic          ovf_sticky, ovf_sticky2;
    logic [7:0]    ovf_cnt;
    logic [1:0]    ovf_cnt2;

    fp12_result_queue #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_z(in_z),
        .in_of(in_of), .in_ready(in_ready), .out_valid(out_valid),
        .out_z(out_z), .out_of(out_of), .out_ready(out_ready),
        .level(level), .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky),
        .ovf_cnt(ovf_cnt)
    );

    fp12_result_queue #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_z(in_z),
        .in_of(in_of), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_z(out_z2), .out_of(out_of2), .out_ready(out_ready),
        .level(level2), .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky2),
        .ovf_cnt(ovf_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents in order, plus statistics as integers.
    logic [12:0] mq[$];
    int          m_cnt;
    int          m_cnt2;
    bit          m_sticky;

    int n_total;
    int n_pass;

    function automatic logic [12:0] m_head();
        return (mq.size() != 0) ? mq[0] : 13'd0;
    endfunction

    // One clock: apply the current inputs to the model, then advance to
    // just after the rising edge so outputs are settled for checking.
    task automatic tick();
        bit p, q, ev;
        p  = in_valid && (mq.size() < DEPTH);
        q  = out_ready && (mq.size() > 0);
        ev = p && in_of;
        @(posedge clk);
        if (q) void'(mq.pop_front());
        if (p) mq.push_back({in_of, in_z});
        if (clr_ovf) begin
            m_cnt    = ev ? 1 : 0;
            m_cnt2   = ev ? 1 : 0;
            m_sticky = ev;
        end else if (ev) begin
            m_sticky = 1'b1;
            if (m_cnt  < 255) m_cnt++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_z      = 12'h000;
        in_of     = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_cnt = 0; m_cnt2 = 0; m_sticky = 1'b0;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out_z !== 12'h000) $display("FAIL reset_out_z got %h exp 000", out_z); else n_pass++;
        n_total++; if (level !== 3'd0) $display("FAIL reset_level got %0d exp 0", level); else n_pass++;
        n_total++; if (ovf_cnt !== 8'd0) $display("FAIL reset_ovf_cnt got %0d exp 0", ovf_cnt); else n_pass++;
        n_total++; if (ovf_sticky !== 1'b0) $display("FAIL reset_ovf_sticky got %b exp 0", ovf_sticky); else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic [11:0] words [4];
        words[0] = 12'h3C0; words[1] = 12'hBC0; words[2] = 12'h440; words[3] = 12'h7FF;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_z = words[i]; in_of = 1'b0;
            tick();
        end
        n_total++; if (level !== 3'd4) $display("FAIL fill_level got %0d exp 4", level); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b exp 0", in_ready); else n_pass++;
        in_z = 12'h123;
        tick();
        n_total++; if (level !== 3'd4) $display("FAIL fifth_push_level got %0d exp 4", level); else n_pass++;
        n_total++; if (out_z !== 12'h3C0) $display("FAIL fifth_push_head got %h exp 3c0", out_z); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_z !== words[i])
                $display("FAIL drain_word%0d got v=%b z=%h exp v=1 z=%h", i, out_valid, out_z, words[i]);
            else n_pass++;
            tick();
            if (i == 0) begin
                n_total++; if (in_ready !== 1'b1) $display("FAIL drain_in_ready got %b exp 1", in_ready); else n_pass++;
            end
        end
        n_total++; if (level !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL drain_empty got level=%0d v=%b exp 0 0", level, out_valid); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_stream();
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1; in_z = 12'(i); in_of = 1'b0;
            tick();
            n_total++;
            if (level !== 3'd1 || out_z !== 12'(i) || out_valid !== 1'b1)
                $display("FAIL stream_word%0d got level=%0d z=%h exp level=1 z=%h", i, level, out_z, 12'(i));
            else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (level !== 3'd0) $display("FAIL stream_end_level got %0d exp 0", level); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_ovf_stats();
        idle_inputs();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_z = 12'($urandom); in_of = (i == 0 || i == 2 || i == 4);
            tick();
        end
        n_total++; if (ovf_cnt !== 8'd3) $display("FAIL ovf_cnt3 got %0d exp 3", ovf_cnt); else n_pass++;
        n_total++; if (ovf_sticky !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf_sticky); else n_pass++;
        clr_ovf = 1'b1; in_of = 1'b1; in_z = 12'($urandom);
        tick();
        clr_ovf = 1'b0;
        n_total++; if (ovf_cnt !== 8'd1 || ovf_sticky !== 1'b1)
            $display("FAIL clr_with_push got cnt=%0d st=%b exp cnt=1 st=1", ovf_cnt, ovf_sticky); else n_pass++;
        clr_ovf = 1'b1; in_valid = 1'b0;
        tick();
        clr_ovf = 1'b0;
        n_total++; if (ovf_cnt !== 8'd0 || ovf_sticky !== 1'b0)
            $display("FAIL clr_only got cnt=%0d st=%b exp 0 0", ovf_cnt, ovf_sticky); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_of = 1'b1; in_z = 12'($urandom);
            tick();
        end
        n_total++; if (ovf_cnt2 !== 2'd3) $display("FAIL sat_cnt2 got %0d exp 3", ovf_cnt2); else n_pass++;
        n_total++; if (ovf_cnt !== 8'd5) $display("FAIL nosat_cnt got %0d exp 5", ovf_cnt); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++; if (ovf_cnt !== 8'd5) $display("FAIL pop_keeps_cnt got %0d exp 5", ovf_cnt); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_full_push_pop();
        logic [12:0] second;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_z = 12'($urandom); in_of = 1'($urandom);
            tick();
        end
        second = mq[1];
        in_valid = 1'b1; out_ready = 1'b1; in_z = 12'hABC;
        tick();
        n_total++; if (level !== 3'd3) $display("FAIL full_pp_level got %0d exp 3", level); else n_pass++;
        n_total++; if ({out_of, out_z} !== second)
            $display("FAIL full_pp_head got %h exp %h", {out_of, out_z}, second); else n_pass++;
        in_valid = 1'b0;
        repeat (3) tick();
        n_total++; if (level !== 3'd0) $display("FAIL full_pp_drain got %0d exp 0", level); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_z      = 12'($urandom);
            in_of     = ($urandom_range(0, 3) == 0);
            clr_ovf   = ($urandom_range(0, 31) == 0);
            tick();
            n_total++;
            if (level !== LW'(mq.size()) || out_valid !== (mq.size() != 0) ||
                {out_of, out_z} !== m_head() || in_ready !== (mq.size() != DEPTH) ||
                ovf_cnt !== 8'(m_cnt) || ovf_sticky !== m_sticky ||
                ovf_cnt2 !== 2'(m_cnt2) || ovf_sticky2 !== m_sticky ||
                {out_of2, out_z2} !== m_head() || level2 !== LW'(mq.size()) ||
                out_valid2 !== (mq.size() != 0) || in_ready2 !== (mq.size() != DEPTH))
                $display("FAIL random_c%0d got lvl=%0d head=%h cnt=%0d st=%b cnt2=%0d exp lvl=%0d head=%h cnt=%0d st=%b cnt2=%0d",
                         c, level, {out_of, out_z}, ovf_cnt, ovf_sticky, ovf_cnt2,
                         mq.size(), m_head(), m_cnt, m_sticky, m_cnt2);
            else n_pass++;
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (DEPTH) tick();
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_z = 12'($urandom) | 12'h001; in_of = 1'b1;
            tick();
        end
        idle_inputs();
        n_total++; if (level !== 3'd2) $display("FAIL pre_reset_level got %0d exp 2", level); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_cnt = 0; m_cnt2 = 0; m_sticky = 1'b0;
        n_total++; if (out_valid !== 1'b0 || level !== 3'd0 || out_z !== 12'h000)
            $display("FAIL async_reset got v=%b lvl=%0d z=%h exp 0 0 000", out_valid, level, out_z); else n_pass++;
        n_total++; if (ovf_cnt !== 8'd0 || ovf_sticky !== 1'b0)
            $display("FAIL async_reset_stats got cnt=%0d st=%b exp 0 0", ovf_cnt, ovf_sticky); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (out_valid !== 1'b0 || level !== 3'd0)
                $display("FAIL post_reset%0d got v=%b lvl=%0d exp 0 0", i, out_valid, level); else n_pass++;
        end
        in_valid = 1'b1; in_z = 12'h5A5; in_of = 1'b0;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_total++; if (out_z !== 12'h5A5 || level !== 3'd1)
            $display("FAIL post_reset_push got z=%h lvl=%0d exp 5a5 1", out_z, level); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_stream();
        test_ovf_stats();
        test_full_push_pop();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
